// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: operation codes,
// FSM state encoding and small op-decode helpers.
package muldiv_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_t;

    // Bit 1 of the op code selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide engine.
// Multiply: add-shift on a 2*WIDTH accumulator {partial_hi, multiplier}.
// Divide (only when MULDIV_DIV_EN is defined): restoring trial-subtract-shift
// on {remainder, dividend/quotient}.
module muldiv_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic                 div_mode,
`endif
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] mul_sum_s;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] div_shift_s;
    logic [WIDTH:0] div_trial_s;
`endif

    // Single iteration: multiplier LSB gates the add, carry shifts into the top.
    always_comb begin
        mul_sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        acc_next  = {mul_sum_s, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Shifted remainder needs one extra bit so the trial borrow is visible.
        div_shift_s = acc[2*WIDTH-1:WIDTH-1];
        div_trial_s = div_shift_s - {1'b0, operand};
        if (div_mode) begin
            if (div_trial_s[WIDTH] == 1'b0) begin
                acc_next = {div_trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {div_shift_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum_s, acc[WIDTH-1:1]};
        end
`endif
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO.
// Runs WIDTH iterations on operand magnitudes, then one sign fix-up cycle.
// Optional feature macro: MULDIV_DIV_EN (enables DIV/DIVU; without it the
// divide datapath is absent and divide requests are ignored).
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       MdOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiWE,
    input  logic             LoWE,
    input  logic [WIDTH-1:0] MtDataE,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             MdBusy,
    output logic             MdDone
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state_r, state_s;
    logic [CW-1:0]      count_r;
    logic [2*WIDTH-1:0] acc_r, acc_step_s, prod_s;
    logic [WIDTH-1:0]   operand_r;
    logic               neg_res_r;
    logic               op_legal_s, start_ok_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s, hi_fix_s, lo_fix_s;
`ifdef MULDIV_DIV_EN
    logic               is_div_r, neg_rem_r;
`endif

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
        .div_mode (is_div_r),
`endif
        .acc      (acc_r),
        .operand  (operand_r),
        .acc_next (acc_step_s)
    );

    // Start qualification and operand magnitude/sign extraction.
    always_comb begin
`ifdef MULDIV_DIV_EN
        op_legal_s = 1'b1;
`else
        op_legal_s = ~MdOpE[1];
`endif
        start_ok_s = StartE & op_legal_s & (state_r == ST_IDLE);
        a_neg_s    = op_is_signed(MdOpE) & SrcAE[WIDTH-1];
        b_neg_s    = op_is_signed(MdOpE) & SrcBE[WIDTH-1];
        a_mag_s    = a_neg_s ? neg_w(SrcAE) : SrcAE;
        b_mag_s    = b_neg_s ? neg_w(SrcBE) : SrcBE;
    end

    // Next-state logic: IDLE -> RUN for WIDTH cycles -> FIX -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_s = ST_RUN;
                else            state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (count_r == {CW{1'b0}}) state_s = ST_FIX;
                else                       state_s = ST_RUN;
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Sign fix-up of the raw magnitude result in FIX.
    always_comb begin
        prod_s   = neg_res_r ? neg_2w(acc_r) : acc_r;
        hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
        lo_fix_s = prod_s[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_r) begin
            lo_fix_s = neg_res_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            hi_fix_s = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH])
                                 : acc_r[2*WIDTH-1:WIDTH];
        end else begin
            hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
            lo_fix_s = prod_s[WIDTH-1:0];
        end
`endif
    end

    // State register with registered busy/done so nothing combinational reaches the hazard unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            MdBusy  <= 1'b0;
            MdDone  <= 1'b0;
        end else begin
            state_r <= state_s;
            MdBusy  <= (state_s != ST_IDLE);
            MdDone  <= (state_r == ST_FIX);
        end
    end

    // Datapath: operand capture, iteration, HI/LO write-back and MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r   <= {CW{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            operand_r <= {WIDTH{1'b0}};
            neg_res_r <= 1'b0;
            Hi        <= {WIDTH{1'b0}};
            Lo        <= {WIDTH{1'b0}};
`ifdef MULDIV_DIV_EN
            is_div_r  <= 1'b0;
            neg_rem_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        count_r   <= CW'(WIDTH-1);
                        neg_res_r <= a_neg_s ^ b_neg_s;
`ifdef MULDIV_DIV_EN
                        is_div_r  <= op_is_div(MdOpE);
                        neg_rem_r <= a_neg_s;
                        if (op_is_div(MdOpE)) begin
                            acc_r     <= {{WIDTH{1'b0}}, a_mag_s};
                            operand_r <= b_mag_s;
                        end else begin
                            acc_r     <= {{WIDTH{1'b0}}, b_mag_s};
                            operand_r <= a_mag_s;
                        end
`else
                        acc_r     <= {{WIDTH{1'b0}}, b_mag_s};
                        operand_r <= a_mag_s;
`endif
                    end else if (!StartE) begin
                        // A coincident start always drops the move.
                        if (HiWE) Hi <= MtDataE;
                        if (LoWE) Lo <= MtDataE;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_step_s;
                    count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                end
                ST_FIX: begin
                    Hi <= hi_fix_s;
                    Lo <= lo_fix_s;
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset, StartE, HiWE, LoWE;
    logic [1:0]  MdOpE;
    logic [31:0] SrcAE, SrcBE, MtDataE, Hi, Lo;
    logic        MdBusy, MdDone;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_hi, exp_lo;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .StartE  (StartE),
        .MdOpE   (MdOpE),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .HiWE    (HiWE),
        .LoWE    (LoWE),
        .MtDataE (MtDataE),
        .Hi      (Hi),
        .Lo      (Lo),
        .MdBusy  (MdBusy),
        .MdDone  (MdDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {HI, LO} from plain arithmetic on magnitudes plus sign rules.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic        sgn, sa, sb;
        logic [31:0] ma, mb, q, r;
        logic [63:0] p;
        sgn = (op[0] == 1'b0);
        sa  = sgn & a[31];
        sb  = sgn & b[31];
        ma  = sa ? (32'd0 - a) : a;
        mb  = sb ? (32'd0 - b) : b;
        if (op[1] == 1'b0) begin
            p = {32'd0, ma} * {32'd0, mb};
            if (sa ^ sb) p = 64'd0 - p;
            return p;
        end
        if (mb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sa ^ sb) q = 32'd0 - q;
        if (sa) r = 32'd0 - r;
        return {r, q};
    endfunction

    // Issue one op from IDLE; on return the bench sits in the MdDone cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [63:0] r;
        int          busy_cnt;
        StartE = 1'b1;
        MdOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
        tick();
        StartE = 1'b0;
        SrcAE  = $urandom;
        SrcBE  = $urandom;
        MdOpE  = 2'($urandom_range(0, 3));
        if (DIV_EN || !op[1]) begin
            r        = ref_md(op, a, b);
            exp_hi   = r[63:32];
            exp_lo   = r[31:0];
            busy_cnt = 0;
            while (MdBusy === 1'b1 && busy_cnt < 200) begin
                busy_cnt++;
                tick();
            end
            check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
            check({tag, "_done"}, {63'd0, MdDone}, 64'd1);
            check({tag, "_hi"}, {32'd0, Hi}, {32'd0, exp_hi});
            check({tag, "_lo"}, {32'd0, Lo}, {32'd0, exp_lo});
        end else begin
            check({tag, "_nobusy"}, {63'd0, MdBusy}, 64'd0);
            tick();
            check({tag, "_nobusy2"}, {63'd0, MdBusy}, 64'd0);
            check({tag, "_nodone"}, {63'd0, MdDone}, 64'd0);
            check({tag, "_hi_hold"}, {32'd0, Hi}, {32'd0, exp_hi});
            check({tag, "_lo_hold"}, {32'd0, Lo}, {32'd0, exp_lo});
        end
    endtask

    // Main stimulus sequence.
    initial begin
        logic [63:0] r;
        logic [31:0] a, b;
        logic [1:0]  op;
        int          guard;

        reset = 1'b1; StartE = 1'b0; HiWE = 1'b0; LoWE = 1'b0;
        MdOpE = 2'b00; SrcAE = 32'd0; SrcBE = 32'd0; MtDataE = 32'd0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_hi", {32'd0, Hi}, 64'd0);
        check("rst_lo", {32'd0, Lo}, 64'd0);
        check("rst_busy", {63'd0, MdBusy}, 64'd0);
        check("rst_done", {63'd0, MdDone}, 64'd0);

        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
        tick();
        check("done_single_pulse", {63'd0, MdDone}, 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(2'b11, 32'd7, 32'd0, "divu_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, "div_neg_by0");
        tick();

        // MTLO / MTHI in IDLE take effect at the next edge.
        LoWE = 1'b1; MtDataE = 32'h0000_1234;
        tick();
        LoWE = 1'b0; exp_lo = 32'h0000_1234;
        check("mtlo", {32'd0, Lo}, {32'd0, exp_lo});
        HiWE = 1'b1; MtDataE = 32'hCAFE_0001;
        tick();
        HiWE = 1'b0; exp_hi = 32'hCAFE_0001;
        check("mthi", {32'd0, Hi}, {32'd0, exp_hi});

        // Randomized ops, issued back-to-back in each MdDone cycle.
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (i % 6 == 1) b = 32'd0;
            if (i % 6 == 2) a = 32'h8000_0000;
            if (i % 6 == 3) b = 32'($urandom_range(1, 9));
            run_op(op, a, b, "rand");
        end
        tick();

        // Start and HiWE while busy are both ignored.
        a = 32'h1234_5678; b = 32'hFFFF_FF00;
        r = ref_md(2'b00, a, b);
        StartE = 1'b1; MdOpE = 2'b00; SrcAE = a; SrcBE = b;
        tick();
        StartE = 1'b0;
        repeat (4) tick();
        StartE = 1'b1; MdOpE = 2'b01; SrcAE = 32'd5; SrcBE = 32'd9;
        HiWE = 1'b1; MtDataE = 32'hDEAD_BEEF;
        tick();
        StartE = 1'b0; HiWE = 1'b0;
        guard = 0;
        while (MdBusy === 1'b1 && guard < 200) begin
            guard++;
            tick();
        end
        check("busy_ignore_done", {63'd0, MdDone}, 64'd1);
        check("busy_ignore_hi", {32'd0, Hi}, {32'd0, r[63:32]});
        check("busy_ignore_lo", {32'd0, Lo}, {32'd0, r[31:0]});
        tick();
        check("busy_ignore_idle", {63'd0, MdBusy}, 64'd0);

        // Reset in flight discards the op and clears HI/LO.
        StartE = 1'b1; MdOpE = 2'b01; SrcAE = 32'h0000_FFFF; SrcBE = 32'h0000_FFFF;
        tick();
        StartE = 1'b0;
        repeat (9) tick();
        check("midop_busy", {63'd0, MdBusy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_hi", {32'd0, Hi}, 64'd0);
        check("midrst_lo", {32'd0, Lo}, 64'd0);
        check("midrst_busy", {63'd0, MdBusy}, 64'd0);
        repeat (30) tick();
        check("midrst_no_done", {63'd0, MdDone}, 64'd0);
        check("midrst_lo_kept0", {32'd0, Lo}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
